// File: rtl/fix_pkg.sv
// Shared fixed-point helpers: format width derivations, saturation bounds
// and the dot-product engine state encoding.
package fix_pkg;

  typedef enum logic [1:0] {
    S_ACC   = 2'd0,
    S_DRAIN = 2'd1,
    S_OUT   = 2'd2
  } state_e;

  // Sign bit plus integer and fractional bits.
  function automatic int total_bits_f(input int int_bits, input int frac_bits);
    return int_bits + frac_bits + 1;
  endfunction

  // Scaled product width plus headroom for summing many products.
  function automatic int acc_w_f(input int int_bits, input int frac_bits,
                                 input int guard_bits);
    return 2 * total_bits_f(int_bits, frac_bits) - frac_bits + guard_bits;
  endfunction

  // Largest positive code; formats wider than 64 bits are not supported.
  function automatic logic signed [63:0] sat_max_f(input int int_bits,
                                                   input int frac_bits);
    return (64'sd1 <<< (int_bits + frac_bits)) - 64'sd1;
  endfunction

  // Symmetric negative bound: the most-negative code is reserved because the
  // float converter downstream reads it as -0.
  function automatic logic signed [63:0] sat_min_f(input int int_bits,
                                                   input int frac_bits);
    return -sat_max_f(int_bits, frac_bits);
  endfunction

endpackage

// File: rtl/fix_sat.sv
// Combinational symmetric clamp from a wide accumulator to the
// Q(INT_BITS).(FRAC_BITS) result format, flagging when the clamp applies.
module fix_sat
  import fix_pkg::*;
#(
  parameter int INT_BITS  = 4,
  parameter int FRAC_BITS = 30,
  parameter int IN_W      = 48,
  localparam int OUT_W    = total_bits_f(INT_BITS, FRAC_BITS)
) (
  input  logic signed [IN_W-1:0]  val_i,
  output logic signed [OUT_W-1:0] sat_o,
  output logic                    ovf_o
);

  localparam logic signed [OUT_W-1:0] SAT_MAX = OUT_W'(sat_max_f(INT_BITS, FRAC_BITS));
  localparam logic signed [OUT_W-1:0] SAT_MIN = OUT_W'(sat_min_f(INT_BITS, FRAC_BITS));

  logic [IN_W-OUT_W:0] hi;
  logic                in_range;

  // Value fits when all bits from the output sign upward agree, excluding the
  // reserved most-negative code (ones above, all zeros below).
  always_comb begin
    hi       = val_i[IN_W-1:OUT_W-1];
    in_range = (hi == '0) || ((hi == '1) && (val_i[OUT_W-2:0] != '0));
    ovf_o    = !in_range;
    if (in_range) begin
      sat_o = val_i[OUT_W-1:0];
    end else if (val_i[IN_W-1]) begin
      sat_o = SAT_MIN;
    end else begin
      sat_o = SAT_MAX;
    end
  end

endmodule

// File: rtl/fix_dot_acc.sv
// Streaming fixed-point dot-product engine: multiply, scale, accumulate,
// saturate. Optional build macro FIX_DOT_ACC_ROUND_EN selects round-half-up
// per product instead of truncation toward -inf; latency is unchanged.
module fix_dot_acc
  import fix_pkg::*;
#(
  parameter int INT_BITS   = 4,
  parameter int FRAC_BITS  = 30,
  parameter int GUARD_BITS = 8,
  parameter int MAX_LEN    = 256,
  localparam int TOTAL_BITS = total_bits_f(INT_BITS, FRAC_BITS)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic                         in_last_i,
  input  logic signed [TOTAL_BITS-1:0] a_i,
  input  logic signed [TOTAL_BITS-1:0] b_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic        [TOTAL_BITS-1:0] fixed_o,
  output logic                         ovf_o,
  output logic                         len_err_o
);

  localparam int PROD_W = 2 * TOTAL_BITS;
  localparam int ACC_W  = acc_w_f(INT_BITS, FRAC_BITS, GUARD_BITS);
  localparam int EXT_W  = PROD_W + GUARD_BITS;
  localparam int CNT_W  = $clog2(MAX_LEN) + 1;
`ifdef FIX_DOT_ACC_ROUND_EN
  localparam logic signed [EXT_W-1:0] RND_C = EXT_W'(1) <<< (FRAC_BITS - 1);
`else
  localparam logic signed [EXT_W-1:0] RND_C = '0;
`endif

  // Sign-extend, optionally round, then drop FRAC_BITS to realign the binary
  // point; the result always fits ACC_W by construction.
  function automatic logic signed [ACC_W-1:0] scale_f(input logic signed [PROD_W-1:0] p);
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] sh;
    ext = EXT_W'(p);
    sh  = (ext + RND_C) >>> FRAC_BITS;
    return ACC_W'(sh);
  endfunction

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q;
  logic                      first_q;
  logic                      vld_p0_q, last_p0_q;
  logic                      last_p1_q;
  logic                      len_err_q, ovf_q;
  logic [TOTAL_BITS-1:0]     fixed_q;
  logic signed [PROD_W-1:0]  prod_p0_q;
  logic signed [ACC_W-1:0]   acc_p1_q, acc_d;
  logic signed [PROD_W-1:0]  a_ext, b_ext;
  logic signed [TOTAL_BITS-1:0] sat_val;
  logic                      sat_ovf;
  logic                      in_hs, out_hs, cnt_max, end_beat;

  assign in_ready_o  = (state_q == S_ACC) && !rst_i;
  assign out_valid_o = (state_q == S_OUT);
  assign fixed_o     = fixed_q;
  assign ovf_o       = ovf_q;
  assign len_err_o   = len_err_q;

  assign in_hs    = in_valid_i && in_ready_o;
  assign out_hs   = out_valid_o && out_ready_i;
  assign cnt_max  = (cnt_q == CNT_W'(MAX_LEN - 1));
  assign end_beat = in_hs && (in_last_i || cnt_max);
  assign a_ext    = PROD_W'(a_i);
  assign b_ext    = PROD_W'(b_i);

  // Next-state logic: accept beats, wait for the last product to land, present.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ACC:   if (end_beat)    state_d = S_DRAIN;
      S_DRAIN: if (last_p1_q)   state_d = S_OUT;
      S_OUT:   if (out_ready_i) state_d = S_ACC;
      default:                  state_d = S_ACC;
    endcase
  end

  // Overwrite on the first beat of a vector, otherwise add.
  always_comb begin
    acc_d = first_q ? scale_f(prod_p0_q) : acc_p1_q + scale_f(prod_p0_q);
  end

  fix_sat #(
    .INT_BITS  (INT_BITS),
    .FRAC_BITS (FRAC_BITS),
    .IN_W      (ACC_W)
  ) u_sat (
    .val_i (acc_p1_q),
    .sat_o (sat_val),
    .ovf_o (sat_ovf)
  );

  // Control and result registers: FSM, beat count, stage valids, flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_ACC;
      cnt_q     <= '0;
      first_q   <= 1'b1;
      vld_p0_q  <= 1'b0;
      last_p0_q <= 1'b0;
      last_p1_q <= 1'b0;
      len_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      fixed_q   <= '0;
    end else begin
      state_q <= state_d;
      // stage p0: product captured on handshake
      vld_p0_q  <= in_hs;
      last_p0_q <= end_beat;
      // stage p1: product folded into the accumulator
      last_p1_q <= vld_p0_q && last_p0_q;
      if (out_hs)        first_q <= 1'b1;
      else if (vld_p0_q) first_q <= 1'b0;
      if (out_hs)     cnt_q <= '0;
      else if (in_hs) cnt_q <= cnt_q + 1'b1;
      if (out_hs)                              len_err_q <= 1'b0;
      else if (in_hs && cnt_max && !in_last_i) len_err_q <= 1'b1;
      // stage p2: saturated result registered for output
      if (last_p1_q) begin
        fixed_q <= sat_val;
        ovf_q   <= sat_ovf;
      end else if (out_hs) begin
        ovf_q   <= 1'b0;
      end
    end
  end

  // Datapath registers carry no reset; stage valids qualify their contents.
  always_ff @(posedge clk_i) begin
    if (in_hs)    prod_p0_q <= a_ext * b_ext;
    if (vld_p0_q) acc_p1_q  <= acc_d;
  end

endmodule

// File: tb/tb_fix_dot_acc.sv
module tb_fix_dot_acc;

  localparam int TB_MAX = 8;
  localparam logic signed [69:0] MAX70 = (70'sd1 <<< 34) - 70'sd1;

  typedef struct {
    logic [34:0] fx;
    logic        ovf;
    logic        lerr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [34:0] a = '0, b = '0;
  logic        in_ready, out_valid, ovf, len_err;
  logic [34:0] fixed;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  fix_dot_acc #(.MAX_LEN(TB_MAX)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_last_i   (in_last),
    .a_i         (a),
    .b_i         (b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .fixed_o     (fixed),
    .ovf_o       (ovf),
    .len_err_o   (len_err)
  );

  always #5 clk = ~clk;

  // Drive n beats of the same pair; model the result and push it when the
  // vector ends (last flag or forced termination at TB_MAX beats).
  task automatic send_beats(input logic [34:0] av, input logic [34:0] bv,
                            input int n, input bit last_final);
    logic signed [69:0] pa, pb, p, acc;
    exp_t e;
    bit   ended;
    acc = '0;
    ended = 0;
    for (int i = 0; i < n && !ended; i++) begin
      int w;
      @(negedge clk);
      in_valid = 1'b1; a = av; b = bv; in_last = last_final && (i == n - 1);
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      if (!in_ready) begin
        errors++;
        $display("FAIL in_ready_timeout got=%0b want=1", in_ready);
      end
      @(posedge clk);
      pa = {{35{av[34]}}, av};
      pb = {{35{bv[34]}}, bv};
      p  = pa * pb;
`ifdef FIX_DOT_ACC_ROUND_EN
      p  = p + (70'sd1 <<< 29);
`endif
      acc = acc + (p >>> 30);
      if (in_last || i == TB_MAX - 1) begin
        ended  = 1;
        e.lerr = !in_last;
        if (acc > MAX70)       begin e.fx = 35'(MAX70);  e.ovf = 1'b1; end
        else if (acc < -MAX70) begin e.fx = 35'(-MAX70); e.ovf = 1'b1; end
        else                   begin e.fx = 35'(acc);    e.ovf = 1'b0; end
        sb.push_back(e);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Wait (bounded) for out_valid at negedges, counting from the negedge after
  // the last handshake; pop the matching expected entry.
  task automatic get_result(output exp_t e, output int lat, output bit have);
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!out_valid) lat = -1;
    have = (sb.size() != 0);
    if (have) e = sb.pop_front();
    else begin e.fx = 'x; e.ovf = 1'bx; e.lerr = 1'bx; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready got=%0b want=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
    checks++; if (fixed !== 35'h0)    begin errors++; $display("FAIL rst_fixed got=%h want=0", fixed); end
    checks++; if ({ovf, len_err} !== 2'b00) begin errors++; $display("FAIL rst_flags got=%b want=00", {ovf, len_err}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL post_rst_in_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_single_beat();
    exp_t e; int lat; bit have;
    send_beats(35'h0_6000_0000, 35'h0_8000_0000, 1, 1);
    get_result(e, lat, have);
    checks++; if (lat !== 3) begin errors++; $display("FAIL single_latency got=%0d want=3", lat); end
    checks++; if (fixed !== 35'h0_C000_0000) begin errors++; $display("FAIL single_fixed got=%h want=0c0000000", fixed); end
    checks++; if (!have || fixed !== e.fx || ovf !== e.ovf) begin errors++; $display("FAIL single_sb got=%h/%0b want=%h/%0b", fixed, ovf, e.fx, e.ovf); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_in_ready_out got=%0b want=0", in_ready); end
    @(negedge clk);
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL single_after_hs got=%b want=01", {out_valid, in_ready}); end
  endtask

  task automatic test_four_beat_neg();
    exp_t e; int lat; bit have;
    send_beats(35'h0_4000_0000, 35'h7_E000_0000, 4, 1);
    get_result(e, lat, have);
    checks++; if (lat !== 3) begin errors++; $display("FAIL neg4_latency got=%0d want=3", lat); end
    checks++; if (fixed !== 35'h7_8000_0000 || ovf !== 1'b0) begin errors++; $display("FAIL neg4_fixed got=%h/%0b want=780000000/0", fixed, ovf); end
    checks++; if (!have || fixed !== e.fx) begin errors++; $display("FAIL neg4_sb got=%h want=%h", fixed, e.fx); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    exp_t e; int lat; bit have;
    send_beats(35'h1_C000_0000, 35'h1_C000_0000, 8, 1);
    get_result(e, lat, have);
    checks++; if (fixed !== 35'h3_FFFF_FFFF || ovf !== 1'b1) begin errors++; $display("FAIL ovf_pos got=%h/%0b want=3ffffffff/1", fixed, ovf); end
    checks++; if (!have || {fixed, ovf, len_err} !== {e.fx, e.ovf, e.lerr}) begin errors++; $display("FAIL ovf_pos_sb got=%h/%0b/%0b want=%h/%0b/%0b", fixed, ovf, len_err, e.fx, e.ovf, e.lerr); end
    @(negedge clk);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0b want=0", ovf); end
    send_beats(35'h6_4000_0000, 35'h1_C000_0000, 8, 1);
    get_result(e, lat, have);
    checks++; if (fixed !== 35'h4_0000_0001 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_neg got=%h/%0b want=400000001/1", fixed, ovf); end
    checks++; if (!have || fixed !== e.fx) begin errors++; $display("FAIL ovf_neg_sb got=%h want=%h", fixed, e.fx); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    exp_t e; int lat; bit have;
    logic [34:0] held;
    out_ready = 1'b0;
    send_beats(35'h0_4000_0000, 35'h1_0000_0000, 1, 1);
    get_result(e, lat, have);
    held = fixed;
    checks++; if (!have || fixed !== e.fx) begin errors++; $display("FAIL bp_value got=%h want=%h", fixed, e.fx); end
    in_valid = 1'b1; a = 35'h1_C000_0000; b = 35'h1_C000_0000; in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || fixed !== held || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got=%0b/%h/%0b want=1/%h/0", i, out_valid, fixed, in_ready, held);
      end
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got=%b want=01", {out_valid, in_ready}); end
    send_beats(35'h0_6000_0000, 35'h0_8000_0000, 1, 1);
    get_result(e, lat, have);
    checks++; if (fixed !== 35'h0_C000_0000 || lat !== 3) begin errors++; $display("FAIL bp_next got=%h lat=%0d want=0c0000000 lat=3", fixed, lat); end
    @(negedge clk);
  endtask

  task automatic test_len_err();
    exp_t e; int lat; bit have;
    send_beats(35'h0_1000_0000, 35'h0_4000_0000, TB_MAX, 0);
    get_result(e, lat, have);
    checks++; if (lat !== 3) begin errors++; $display("FAIL len_latency got=%0d want=3", lat); end
    checks++; if (len_err !== 1'b1 || fixed !== 35'h0_8000_0000) begin errors++; $display("FAIL len_err got=%0b/%h want=1/080000000", len_err, fixed); end
    checks++; if (!have || len_err !== e.lerr) begin errors++; $display("FAIL len_sb got=%0b want=%0b", len_err, e.lerr); end
    @(negedge clk);
    checks++; if ({in_ready, len_err} !== 2'b10) begin errors++; $display("FAIL len_after_hs got=%b want=10", {in_ready, len_err}); end
  endtask

  task automatic test_rounding();
    exp_t e; int lat; bit have;
    logic [34:0] want;
`ifdef FIX_DOT_ACC_ROUND_EN
    want = 35'h1;
`else
    want = 35'h0;
`endif
    send_beats(35'h0_0000_0001, 35'h0_2000_0000, 1, 1);
    get_result(e, lat, have);
    checks++; if (fixed !== want) begin errors++; $display("FAIL round got=%h want=%h", fixed, want); end
    checks++; if (!have || fixed !== e.fx) begin errors++; $display("FAIL round_sb got=%h want=%h", fixed, e.fx); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    exp_t e; int lat; bit have;
    send_beats(35'h1_C000_0000, 35'h1_C000_0000, 2, 0);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL midrst_ctrl got=%b want=00", {out_valid, in_ready}); end
    rst = 1'b0;
    @(negedge clk);
    send_beats(35'h0_6000_0000, 35'h0_8000_0000, 1, 1);
    get_result(e, lat, have);
    checks++; if (fixed !== 35'h0_C000_0000 || lat !== 3) begin errors++; $display("FAIL midrst_next got=%h lat=%0d want=0c0000000 lat=3", fixed, lat); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat; bit have;
    send_beats(35'h0_4000_0000, 35'h0_4000_0000, 3, 1);
    get_result(e, lat, have);
    checks++; if (!have || fixed !== e.fx || fixed !== 35'h0_C000_0000) begin errors++; $display("FAIL b2b_first got=%h want=0c0000000", fixed); end
    @(negedge clk);
    send_beats(35'h7_C000_0000, 35'h0_2000_0000, 2, 1);
    get_result(e, lat, have);
    checks++; if (!have || fixed !== e.fx || fixed !== 35'h7_C000_0000) begin errors++; $display("FAIL b2b_second got=%h want=7c0000000", fixed); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_four_beat_neg();
    test_overflow();
    test_backpressure();
    test_len_err();
    test_rounding();
    test_mid_reset();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
